// File: rtl/nr_sig_div_if.sv
// Handshake and operand/result bundle for the non-restoring significand divider.
interface nr_sig_div_if #(
    parameter int WIDTH = 24
);
    logic             start;
    logic [WIDTH-1:0] dividend_sig;
    logic [WIDTH-1:0] divisor_sig;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] quotient;
    logic             sticky;
    logic             div_zero;

    modport master (
        output start, dividend_sig, divisor_sig,
        input  busy, valid, quotient, sticky, div_zero
    );

    modport slave (
        input  start, dividend_sig, divisor_sig,
        output busy, valid, quotient, sticky, div_zero
    );
endinterface

// File: rtl/nr_sig_div.sv
// Iterative non-restoring significand divider: one quotient bit per clock,
// 24-bit quotient plus sticky for the single-precision DIV path.
module nr_sig_div #(
    parameter int WIDTH = 24
) (
    input  logic         clk,
    input  logic         rst,
    nr_sig_div_if.slave  bus
);
    // Two guard bits keep 2R +/- B representable for legal inputs (A < 2B).
    localparam int RW    = WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state, state_nxt;
    logic signed [RW-1:0]    rem_r;
    logic signed [RW-1:0]    div_r;
    logic [CNT_W-1:0]        cnt;
    logic [WIDTH-1:0]        q_r;
    logic                    dz_r;

    // One non-restoring step: add back on a negative remainder, else subtract.
    function automatic logic signed [RW-1:0] nr_step(
        input logic signed [RW-1:0] rem,
        input logic signed [RW-1:0] d
    );
        logic signed [RW-1:0] dbl;
        dbl = rem <<< 1;
        return rem[RW-1] ? (dbl + d) : (dbl - d);
    endfunction

    // Sticky from the corrected (non-negative) final remainder.
    function automatic logic rem_nonzero(
        input logic signed [RW-1:0] rem,
        input logic signed [RW-1:0] d
    );
        logic signed [RW-1:0] fix;
        fix = rem[RW-1] ? (rem + d) : rem;
        return (fix != '0);
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    // Datapath: operand capture, iteration, and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r        <= '0;
            div_r        <= '0;
            cnt          <= '0;
            q_r          <= '0;
            dz_r         <= 1'b0;
            bus.valid    <= 1'b0;
            bus.quotient <= '0;
            bus.sticky   <= 1'b0;
            bus.div_zero <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        div_r <= $signed({2'b00, bus.divisor_sig});
                        dz_r  <= (bus.divisor_sig == '0);
                        rem_r <= $signed({2'b00, bus.dividend_sig})
                               - $signed({2'b00, bus.divisor_sig});
                        cnt   <= CNT_W'(WIDTH - 1);
                    end
                end
                CALC: begin
                    q_r[cnt] <= ~rem_r[RW-1];
                    if (cnt != '0) begin
                        rem_r <= nr_step(rem_r, div_r);
                        cnt   <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // A zero divisor forces the saturated quotient and drops the iteration result.
                    bus.quotient <= dz_r ? '1 : q_r;
                    bus.sticky   <= dz_r ? 1'b0 : rem_nonzero(rem_r, div_r);
                    bus.div_zero <= dz_r;
                    bus.valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/nr_sig_div.md
Name: nr_sig_div

Overview:
Iterative non-restoring significand divider for the IEEE754 single-precision DIV path. It accepts two 24-bit significands with the hidden bit included and produces one quotient bit per clock. The result is a 24-bit quotient plus a sticky bit. The quotient feeds the leading-one detector and normaliser directly downstream. When dividend < divisor, quotient bit 23 is 0 and the detector reports a shift-left of 1.

Parameters:
WIDTH, 24, significand width including the hidden bit; the iteration counter is sized from WIDTH.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, synchronous, active-high.
start  input  1  request pulse; sampled only in IDLE.
dividend_sig  input  WIDTH  dividend significand A; bit WIDTH-1 = 1, or all zeros.
divisor_sig  input  WIDTH  divisor significand B; bit WIDTH-1 = 1, or all zeros.
busy  output  1  high while an operation is in flight.
valid  output  1  one-cycle pulse; quotient, sticky and div_zero are valid in that cycle.
quotient  output  WIDTH  floor(A * 2^(WIDTH-1) / B).
sticky  output  1  1 when the final remainder is non-zero.
div_zero  output  1  1 when divisor_sig = 0.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state = IDLE; busy, valid, sticky, div_zero, quotient = 0; internal remainder and counter = 0.
- rst asserted mid-operation aborts the operation: back to IDLE next edge, no valid pulse, outputs cleared.
- States: IDLE, CALC, DONE.
- IDLE, start = 1 (edge E0):
  - capture B and the div_zero condition;
  - R <= A - B (signed, WIDTH+2 bits);
  - cnt <= WIDTH-1;
  - state -> CALC; busy = 1 from the next cycle.
- CALC, each edge (E1..E24 for WIDTH = 24):
  - q[cnt] <= ~R.sign;
  - if cnt != 0: R <= R.sign ? 2R + B : 2R - B, and cnt <= cnt - 1;
  - if cnt = 0: state -> DONE, R holds.
- DONE (edge E25):
  - quotient <= q;
  - sticky <= ((R.sign ? R + B : R) != 0);
  - valid <= 1, busy <= 0;
  - state -> IDLE.
- Latency: valid is high in the cycle after edge E0+WIDTH+1 (25 cycles for WIDTH = 24). Throughput is one operation per WIDTH+2 cycles.
- valid deasserts after exactly one cycle. quotient, sticky and div_zero hold until the next DONE or reset.
- start while busy is ignored, with no effect on the operation in flight. start in the same cycle valid is high is accepted, because state is already IDLE.
- Width rule: legal inputs satisfy A < 2B, which keeps R in [-B, B) after every step. The intermediate 2R ± B fits WIDTH+2 signed bits.
- Quotient range is [2^(WIDTH-2), 2^WIDTH - 1]. Bit WIDTH-1 = 1 iff A >= B.
- A = 0 (B normalised): quotient = 0, sticky = 0, normal latency.
- B = 0:
  - div_zero = 1, quotient = all ones, sticky = 0;
  - same latency and handshake; the iteration result is discarded.
- Non-zero, unnormalised operands (bit WIDTH-1 = 0) are illegal. The result is unspecified, but the FSM still returns to IDLE after WIDTH+2 cycles.

Test Plan:
- A = 0x800000, B = 0x800000 -> quotient 0x800000, sticky 0, div_zero 0; valid exactly 25 cycles after the start edge, for one cycle.
- A = 0xC00000, B = 0x800000 -> quotient 0xC00000, sticky 0.
- A = 0x800000, B = 0xC00000 -> quotient 0x555555 (bit 23 = 0), sticky 1.
- A = 0xFFFFFF, B = 0x800001 -> quotient 0xFFFFFD, sticky 1. Then A = 0xFFFFFF, B = 0x800000 -> quotient 0xFFFFFF, sticky 0.
- B = 0x000000, A = 0x900000 -> div_zero 1, quotient 0xFFFFFF, sticky 0, same latency. Then A = 0, B = 0x800000 -> quotient 0, sticky 0, div_zero 0.
- Control corners:
  - start re-pulsed at cycles 3 and 10 of an operation -> ignored, result unchanged;
  - start on the valid cycle -> second result 25 cycles later;
  - rst at cycle 12 -> no valid pulse, all outputs 0 on the next cycle.
